// File: rtl/pong_timer_pkg.sv
// Shared types and helpers for the Pong countdown timer.
package pong_timer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRun     = 2'b01,
        StPause   = 2'b10,
        StExpired = 2'b11
    } timer_state_e;

    // Bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled game ticks by PRESCALE; qtick fires on the enabled tick that wraps to 0.
module tick_prescaler
    import pong_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic qtick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        qtick = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == Last) begin
                cnt_d = '0;
                qtick = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_countdown_timer.sv
// Down-counting game timer with one-shot/periodic modes, pause and expiry pulse.
// Define PONG_TIMER_PRESCALE_EN to divide timer_tick by PRESCALE before counting.
module pong_countdown_timer
    import pong_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned INIT_VAL = 127,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_start,
    input  logic             load_sel,
    input  logic [WIDTH-1:0] timer_load,
    input  logic             periodic,
    input  logic             timer_tick,
    input  logic             timer_pause,
    output logic [WIDTH-1:0] timer_count,
    output logic             timer_running,
    output logic             timer_up,
    output logic             timer_expired
);

    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT_VAL);

    if (PRESCALE == 0) begin : g_prescale_check
        $error("PRESCALE must be at least 1");
    end

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] start_val;
    logic             periodic_q, periodic_d;
    logic             expired_q, expired_d;
    logic             running_q, up_q;
    logic             tick_en, qtick;

    // Start takes the cycle, so a coincident tick never reaches the counter or prescaler.
    assign tick_en   = timer_tick && (state_q == StRun) && !timer_pause && !timer_start;
    assign start_val = load_sel ? timer_load : InitVal;

`ifdef PONG_TIMER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_start),
        .en   (tick_en),
        .qtick(qtick)
    );
`else
    assign qtick = tick_en;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        if (timer_start) begin
            count_d    = start_val;
            reload_d   = start_val;
            // A zero reload would expire forever, so it is treated as one-shot.
            periodic_d = periodic && (start_val != '0);
            if (start_val == '0) begin
                state_d   = StExpired;
                expired_d = 1'b1;
            end else begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StIdle:    state_d = StIdle;
                StRun: begin
                    if (timer_pause) begin
                        state_d = StPause;
                    end else if (qtick) begin
                        if (count_q == WIDTH'(1)) begin
                            expired_d = 1'b1;
                            if (periodic_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = StExpired;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
                StPause: begin
                    if (!timer_pause) begin
                        state_d = StRun;
                    end
                end
                StExpired: state_d = StExpired;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= InitVal;
            reload_q   <= InitVal;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
            running_q  <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
            running_q  <= (state_d == StRun);
            up_q       <= (state_d == StExpired);
        end
    end

    assign timer_count   = count_q;
    assign timer_running = running_q;
    assign timer_up      = up_q;
    assign timer_expired = expired_q;

endmodule

// File: tb/tb_pong_countdown_timer.sv
// Directed bench for pong_countdown_timer: vector table plus multi-cycle sequences.
module tb_pong_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       timer_start = 1'b0;
    logic       load_sel = 1'b0;
    logic [6:0] timer_load = '0;
    logic       periodic = 1'b0;
    logic       timer_tick = 1'b0;
    logic       timer_pause = 1'b0;
    logic [6:0] timer_count;
    logic       timer_running;
    logic       timer_up;
    logic       timer_expired;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       start;
        logic       sel;
        logic [6:0] load;
        logic       per;
        logic       tick;
        logic       pause;
        logic [6:0] count;
        logic       running;
        logic       up;
        logic       expired;
    } vec_t;

    vec_t vq[$];

    pong_countdown_timer dut (
        .clk          (clk),
        .reset        (reset),
        .timer_start  (timer_start),
        .load_sel     (load_sel),
        .timer_load   (timer_load),
        .periodic     (periodic),
        .timer_tick   (timer_tick),
        .timer_pause  (timer_pause),
        .timer_count  (timer_count),
        .timer_running(timer_running),
        .timer_up     (timer_up),
        .timer_expired(timer_expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [6:0] cnt, input logic run,
                              input logic up, input logic exp);
        check({name, ".count"}, 32'(timer_count), 32'(cnt));
        check({name, ".running"}, 32'(timer_running), 32'(run));
        check({name, ".up"}, 32'(timer_up), 32'(up));
        check({name, ".expired"}, 32'(timer_expired), 32'(exp));
    endtask

    task automatic drive(input logic st, input logic sel, input logic [6:0] ld, input logic per,
                         input logic tk, input logic pz);
        timer_start = st;
        load_sel    = sel;
        timer_load  = ld;
        periodic    = per;
        timer_tick  = tk;
        timer_pause = pz;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic st, input logic sel,
                                input logic [6:0] ld, input logic per, input logic tk,
                                input logic pz, input logic [6:0] cnt, input logic run,
                                input logic up, input logic exp);
        vec_t v;
        v.name = nm; v.start = st; v.sel = sel; v.load = ld; v.per = per;
        v.tick = tk; v.pause = pz; v.count = cnt; v.running = run; v.up = up; v.expired = exp;
        return v;
    endfunction

    initial begin
        int pulses;

        // Periodic reload 3: 9 ticks give three expiries, never 0, never up.
        vq.push_back(mk("t2_start", 1, 1, 7'd3, 1, 0, 0, 7'd3, 1, 0, 0));
        for (int r = 0; r < 3; r++) begin
            vq.push_back(mk("t2_tick_a", 0, 0, 7'd0, 0, 1, 0, 7'd2, 1, 0, 0));
            vq.push_back(mk("t2_tick_b", 0, 0, 7'd0, 0, 1, 0, 7'd1, 1, 0, 0));
            vq.push_back(mk("t2_reload", 0, 0, 7'd0, 0, 1, 0, 7'd3, 1, 0, 1));
        end
        // Pause holds the count and eats ticks, including the release cycle's tick.
        vq.push_back(mk("t3_start", 1, 1, 7'd5, 0, 0, 0, 7'd5, 1, 0, 0));
        vq.push_back(mk("t3_tick1", 0, 0, 7'd0, 0, 1, 0, 7'd4, 1, 0, 0));
        vq.push_back(mk("t3_tick2", 0, 0, 7'd0, 0, 1, 0, 7'd3, 1, 0, 0));
        for (int p = 0; p < 10; p++) begin
            vq.push_back(mk("t3_paused", 0, 0, 7'd0, 0, 1, 1, 7'd3, 0, 0, 0));
        end
        vq.push_back(mk("t3_release", 0, 0, 7'd0, 0, 1, 0, 7'd3, 1, 0, 0));
        vq.push_back(mk("t3_tick3", 0, 0, 7'd0, 0, 1, 0, 7'd2, 1, 0, 0));
        vq.push_back(mk("t3_tick4", 0, 0, 7'd0, 0, 1, 0, 7'd1, 1, 0, 0));
        vq.push_back(mk("t3_expire", 0, 0, 7'd0, 0, 1, 0, 7'd0, 0, 1, 1));
        vq.push_back(mk("t3_after", 0, 0, 7'd0, 0, 1, 0, 7'd0, 0, 1, 0));
        // Start priority, zero load, restarts from EXPIRED and PAUSE.
        vq.push_back(mk("t4_start_tick", 1, 1, 7'd4, 0, 1, 0, 7'd4, 1, 0, 0));
        vq.push_back(mk("t4_tick", 0, 0, 7'd0, 0, 1, 0, 7'd3, 1, 0, 0));
        vq.push_back(mk("t4_zero", 1, 1, 7'd0, 1, 1, 0, 7'd0, 0, 1, 1));
        vq.push_back(mk("t4_zero_hold", 0, 0, 7'd0, 0, 1, 0, 7'd0, 0, 1, 0));
        vq.push_back(mk("t4_zero_hold2", 0, 0, 7'd0, 0, 1, 0, 7'd0, 0, 1, 0));
        vq.push_back(mk("t4_restart_exp", 1, 1, 7'd2, 0, 0, 0, 7'd2, 1, 0, 0));
        vq.push_back(mk("t4_start_pause", 1, 1, 7'd6, 0, 0, 1, 7'd6, 1, 0, 0));
        vq.push_back(mk("t4_pause", 0, 0, 7'd0, 0, 1, 1, 7'd6, 0, 0, 0));
        vq.push_back(mk("t4_restart_pz", 1, 1, 7'd1, 0, 0, 0, 7'd1, 1, 0, 0));
        vq.push_back(mk("t4_one_expire", 0, 0, 7'd0, 0, 1, 0, 7'd0, 0, 1, 1));
        vq.push_back(mk("t4_init_sel", 1, 0, 7'd5, 0, 0, 0, 7'd127, 1, 0, 0));

        // Reset values while reset is still held.
        cyc();
        check_outs("reset", 7'd127, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        check_outs("idle", 7'd127, 0, 0, 0);

`ifndef PONG_TIMER_PRESCALE_EN
        // Full countdown from INIT_VAL with overrun ticks.
        drive(1, 0, 7'd9, 0, 0, 0);
        cyc();
        check_outs("t1_start", 7'd127, 1, 0, 0);
        drive(0, 0, 7'd0, 0, 1, 0);
        pulses = 0;
        for (int k = 1; k <= 130; k++) begin
            cyc();
            if (timer_expired === 1'b1) pulses++;
            check_outs("t1_tick", (k < 127) ? 7'(127 - k) : 7'd0, k < 127, k >= 127, k == 127);
        end
        check("t1_pulses", 32'(pulses), 32'd1);

        foreach (vq[i]) begin
            drive(vq[i].start, vq[i].sel, vq[i].load, vq[i].per, vq[i].tick, vq[i].pause);
            cyc();
            check_outs(vq[i].name, vq[i].count, vq[i].running, vq[i].up, vq[i].expired);
        end

        // Asynchronous reset mid-count at 17.
        drive(1, 1, 7'd20, 0, 0, 0);
        cyc();
        drive(0, 0, 7'd0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cyc();
        check_outs("t5_at17", 7'd17, 1, 0, 0);
        drive(0, 0, 7'd0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 check_outs("t5_async", 7'd127, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 7'd0, 0, 1, 0);
        cyc();
        check_outs("t5_idle1", 7'd127, 0, 0, 0);
        cyc();
        check_outs("t5_idle2", 7'd127, 0, 0, 0);
`else
        // Prescale by 4: load 2 expires on exactly the 8th tick.
        drive(1, 1, 7'd2, 0, 1, 0);
        cyc();
        check_outs("t6_start", 7'd2, 1, 0, 0);
        drive(0, 0, 7'd0, 0, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check_outs("t6_tick", (k < 4) ? 7'd2 : ((k < 8) ? 7'd1 : 7'd0), k < 8, k == 8, k == 8);
        end
        // Restart after two ticks discards the partial prescale.
        drive(1, 1, 7'd2, 0, 0, 0);
        cyc();
        drive(0, 0, 7'd0, 0, 1, 0);
        cyc();
        cyc();
        drive(1, 1, 7'd2, 0, 0, 0);
        cyc();
        drive(0, 0, 7'd0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check_outs("t6_restart", (k < 4) ? 7'd2 : 7'd1, 1, 0, 0);
        end
`endif

        drive(0, 0, 7'd0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
